i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) for the on-chip I2C master; answers a single 7-bit device address on the shared SDA/SCL pair.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and ACKs its address.
- Write transfers: delivers each received byte to the local register/user side.
- Read transfers: serialises bytes requested from the user side onto SDA.

Parameters:
- DEV_ADDR, 7'h2A, target's own 7-bit address (address_t).
- SYNC_STAGES, 2, flip-flop synchroniser depth on SCL and SDA inputs (>=2).

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from master.
- SDA  inout  1  I2C data; open-drain: driven 1'b0 when sda_oe=1, else 'z.
- rx_ready  input  1  user can accept a write byte; 0 at 8th bit causes NACK.
- rx_data  output  8  last received write byte (byte_t).
- rx_valid  output  1  one-clk pulse: rx_data valid.
- tx_req  output  1  one-clk pulse: target needs next read byte.
- tx_data  input  8  read byte; sampled in the clk cycle tx_req=1.
- busy  output  1  1 from address match until STOP/NACK-release.

Behaviour:
- Reset (async, reset_n=0): state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, bit counter=0, synchronisers preset to 1.
- Input path: SCL/SDA pass SYNC_STAGES flops, then one edge-detect register. With SYNC_STAGES=2, events are seen 3 clk after the pin changes.
- Events:
  - scl_rise, scl_fall: edges of synchronised SCL.
  - START: synchronised SDA 1->0 while SCL=1.
  - STOP: synchronised SDA 0->1 while SCL=1.
- Bit sampling and driving:
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except that STOP/START force release.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- IDLE:
  - START -> ADDR.
  - All other activity is ignored.
- ADDR:
  - Shift 8 bits MSB first (7 address bits + R/W).
  - After the 8th scl_rise, on the next scl_fall:
    - Address == DEV_ADDR: assert sda_oe (ACK), busy=1, go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP, SDA released.
- ADDR_ACK, on the scl_fall ending the ACK bit:
  - R/W=0: release SDA, go to WRITE.
  - R/W=1: pulse tx_req, latch tx_data, drive bit7 (sda_oe = ~bit), go to READ.
- WRITE:
  - Shift 8 bits.
  - On the 8th scl_rise: rx_data <= byte and rx_valid pulses, only if rx_ready=1.
  - Next scl_fall:
    - rx_ready was 1: sda_oe=1, go to WRITE_ACK.
    - rx_ready was 0: leave SDA released (NACK), go to WAIT_STOP, busy=0.
- WRITE_ACK: next scl_fall releases SDA, go to WRITE. The bit counter restarts at 0.
- READ:
  - Drive bits 7..0, advancing one bit per scl_fall.
  - After bit0's scl_fall: release SDA, go to READ_ACK.
- READ_ACK, master ack sampled on scl_rise:
  - 0 (ACK): on scl_fall pulse tx_req, load the next byte, drive bit7, go to READ.
  - 1 (NACK): go to WAIT_STOP with SDA released, busy=0.
- WAIT_STOP: stay until STOP -> IDLE, or START -> ADDR.
- Global overrides, any state:
  - STOP: sda_oe=0, busy=0, -> IDLE.
  - START (repeated): sda_oe=0, bit counter=0, busy=0, -> ADDR.
  - STOP/START take priority over a coincident scl edge.
- Partial bytes aborted by START/STOP are discarded; no rx_valid is produced.
- General call (address 0) is NACKed.
- Clock stretching is not supported: SCL is never driven.
- rx_valid and tx_req are never asserted in the same cycle.
- Bit counter: 4 bits, 0..8, with explicit reset on every byte boundary; no wrap beyond 8.

Decomposition:
- my_pkg gains:
  - i2c_tgt_state_t: enum of the 8 states above.
  - I2C_GEN_CALL: constant 7'h00.
- address_t and byte_t are reused from my_pkg.
- Sub-module i2c_bus_monitor holds the synchronisers and edge detection. It outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- i2c_target contains the FSM, shift register and SDA driver.

Test Plan:
- Write to 0x2A, data 8'hA5, rx_ready=1 -> ACK after address and after data; rx_valid pulses once with rx_data=8'hA5; STOP -> busy=0, IDLE.
- Address 0x15 write -> no ACK (SDA stays 'z through the 9th clock), no rx_valid, busy stays 0; next START to 0x2A is ACKed.
- Read from 0x2A, tx_data 8'h3C then 8'hC3, master ACK then NACK -> SDA shows 00111100 then 11000011; exactly 2 tx_req pulses; released after NACK.
- Write 0x2A, bytes 8'h11 then 8'h22 with rx_ready dropped before 2nd byte -> 8'h11 ACKed with rx_valid; 8'h22 NACKed with no rx_valid; WAIT_STOP until STOP.
- Repeated START after 4 data bits of a write, followed by a read of 0x2A -> partial byte discarded, address re-ACKed, read proceeds.
- reset_n=0 mid-READ while driving SDA low -> SDA 'z immediately (asynchronously), all outputs at reset values; recovers on next START.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and constants for the I2C target and its bus monitor.
package my_pkg;

  typedef logic [6:0] address_t;
  typedef logic [7:0] byte_t;

  localparam address_t   I2C_GEN_CALL  = 7'h00;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StWriteAck,
    StRead,
    StReadAck,
    StWaitStop
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and flags clock edges and START/STOP conditions.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Idle bus is high on both lines, so presetting to 1 avoids spurious events after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address: ACKs the address, delivers write bytes and
// serialises read bytes supplied by the user side. SDA is open-drain only.
module i2c_target
  import my_pkg::*;
#(
  parameter address_t    DEV_ADDR    = 7'h2A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  SCL,
  inout  wire   SDA,
  input  logic  rx_ready,
  output byte_t rx_data,
  output logic  rx_valid,
  output logic  tx_req,
  input  byte_t tx_data,
  output logic  busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (SCL),
    .sda      (SDA),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  byte_t          shift_q, shift_d;
  byte_t          rx_data_q, rx_data_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           rw_q, rw_d;
  logic           ack_q, ack_d;
  logic           rx_valid_q, rx_valid_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    rx_valid_d = 1'b0;
    tx_req     = 1'b0;
    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      state_d  = StAddr;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr: begin
          if (scl_rise && cnt_q != BITS_PER_BYTE) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
            cnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR && shift_q[7:1] != I2C_GEN_CALL) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_req   = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = StRead;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrite;
            end
          end
        end
        StWrite: begin
          if (scl_rise && cnt_q != BITS_PER_BYTE) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == BITS_PER_BYTE - 4'd1) begin
              ack_d = rx_ready;
              if (rx_ready) begin
                rx_data_d  = {shift_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
            cnt_d = '0;
            if (ack_q) begin
              sda_oe_d = 1'b1;
              state_d  = StWriteAck;
            end else begin
              busy_d  = 1'b0;
              state_d = StWaitStop;
            end
          end
        end
        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = StWrite;
          end
        end
        StRead: begin
          // cnt counts bits the master has sampled; a fall after the 8th ends the byte.
          if (scl_rise && cnt_q != BITS_PER_BYTE) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            if (cnt_q == BITS_PER_BYTE) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = StReadAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StReadAck: begin
          if (scl_rise && cnt_q == 4'd0) begin
            ack_d = ~sda_s;
            cnt_d = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d = '0;
            if (ack_q) begin
              tx_req   = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = StRead;
            end else begin
              busy_d  = 1'b0;
              state_d = StWaitStop;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a behavioural bus master drives randomised transfers and the
// expected ACKs/data come from simple address and byte-queue rules.
module tb_i2c_target;

  localparam int          ClkP = 10;
  localparam int          Q    = 50;
  localparam logic [6:0]  Dev  = 7'h2A;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCL;
  logic       m_sda_low;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy;
  wire        SDA;

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  always #(ClkP / 2) clk = ~clk;

  i2c_target u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SCL     (SCL),
    .SDA     (SDA),
    .rx_ready(rx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .busy    (busy)
  );

  int checks = 0;
  int errors = 0;

  // Read bytes are served from a list indexed by the number of requests seen so far.
  logic [7:0] tx_mem [64];
  int         tx_cnt = 0;
  int         rx_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  assign tx_data = tx_mem[tx_cnt[5:0]];

  always @(posedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= rx_data;
    end
    if (tx_req) tx_cnt <= tx_cnt + 1;
    if (rx_valid && tx_req) both_cnt <= both_cnt + 1;
  end

  // ---------------- bus master primitives ----------------
  task automatic send_bit(input logic b);
    m_sda_low = ~b;
    #Q SCL = 1'b1;
    #(2 * Q) SCL = 1'b0;
    #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0;
    #Q SCL = 1'b1;
    #Q b = (SDA === 1'b0) ? 1'b0 : 1'b1;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0;
    #Q SCL = 1'b1;
    #(2 * Q) m_sda_low = 1'b1;
    #(2 * Q) SCL = 1'b0;
    #Q;
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1;
    #Q SCL = 1'b1;
    #(2 * Q) m_sda_low = 1'b0;
    #(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] r, input logic master_ack);
    logic b;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      r = {r[6:0], b};
    end
    send_bit(~master_ack);
  endtask

  // Reference rule: only our own non-zero address is acknowledged (ACK = SDA low).
  function automatic logic exp_addr_ack(input logic [6:0] a);
    return (a == Dev && a != 7'h00) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    SCL       = 1'b1;
    m_sda_low = 1'b0;
    rx_ready  = 1'b1;
    #(5 * ClkP);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", SDA); end
    reset_n = 1'b1;
    #(10 * ClkP);
  endtask

  task automatic test_write(input logic [7:0] d);
    int   rx0 = rx_cnt;
    logic a;
    start_cond();
    write_byte({Dev, 1'b0}, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%b exp=0", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
    write_byte(d, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack got=%b exp=0", a); end
    checks++; if (rx_cnt !== rx0 + 1) begin errors++; $display("FAIL wr_rx_count got=%0d exp=%0d", rx_cnt, rx0 + 1); end
    checks++; if (rx_last !== d) begin errors++; $display("FAIL wr_rx_data got=%h exp=%h", rx_last, d); end
    stop_cond();
    #(4 * ClkP);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_wrong_addr(input logic [6:0] addr);
    int   rx0 = rx_cnt;
    logic a;
    start_cond();
    write_byte({addr, 1'b0}, a);
    checks++; if (a !== exp_addr_ack(addr)) begin errors++; $display("FAIL bad_addr_ack addr=%h got=%b exp=%b", addr, a, exp_addr_ack(addr)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy got=%b exp=0", busy); end
    write_byte(8'($urandom), a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bad_addr_data_ack got=%b exp=1", a); end
    checks++; if (rx_cnt !== rx0) begin errors++; $display("FAIL bad_addr_rx got=%0d exp=%0d", rx_cnt, rx0); end
    stop_cond();
  endtask

  task automatic test_read(input logic [7:0] b0, input logic [7:0] b1);
    int         tx0 = tx_cnt;
    logic       a;
    logic [7:0] r;
    tx_mem[tx0[5:0]]     = b0;
    tx_mem[tx0[5:0] + 1] = b1;
    start_cond();
    write_byte({Dev, 1'b1}, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
    read_byte(r, 1'b1);
    checks++; if (r !== b0) begin errors++; $display("FAIL rd_byte0 got=%h exp=%h", r, b0); end
    read_byte(r, 1'b0);
    checks++; if (r !== b1) begin errors++; $display("FAIL rd_byte1 got=%h exp=%h", r, b1); end
    checks++; if (tx_cnt !== tx0 + 2) begin errors++; $display("FAIL rd_tx_req_count got=%0d exp=%0d", tx_cnt - tx0, 2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_nack got=%b exp=0", busy); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL rd_sda_released got=%b exp=1", SDA); end
    stop_cond();
  endtask

  task automatic test_rx_not_ready(input logic [7:0] d0, input logic [7:0] d1);
    int   rx0 = rx_cnt;
    logic a;
    rx_ready = 1'b1;
    start_cond();
    write_byte({Dev, 1'b0}, a);
    write_byte(d0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL nr_first_ack got=%b exp=0", a); end
    rx_ready = 1'b0;
    write_byte(d1, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nr_second_nack got=%b exp=1", a); end
    checks++; if (rx_cnt !== rx0 + 1) begin errors++; $display("FAIL nr_rx_count got=%0d exp=%0d", rx_cnt, rx0 + 1); end
    checks++; if (rx_last !== d0) begin errors++; $display("FAIL nr_rx_data got=%h exp=%h", rx_last, d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nr_busy got=%b exp=0", busy); end
    rx_ready = 1'b1;
    write_byte(8'($urandom), a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nr_wait_stop_nack got=%b exp=1", a); end
    stop_cond();
  endtask

  task automatic test_repeated_start(input logic [7:0] b);
    int         rx0 = rx_cnt;
    logic       a;
    logic [7:0] r;
    logic [7:0] junk = 8'($urandom);
    tx_mem[tx_cnt[5:0]] = b;
    start_cond();
    write_byte({Dev, 1'b0}, a);
    for (int i = 7; i >= 4; i--) send_bit(junk[i]);
    start_cond();
    write_byte({Dev, 1'b1}, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got=%b exp=0", a); end
    read_byte(r, 1'b0);
    checks++; if (r !== b) begin errors++; $display("FAIL rs_read got=%h exp=%h", r, b); end
    checks++; if (rx_cnt !== rx0) begin errors++; $display("FAIL rs_partial_rx got=%0d exp=%0d", rx_cnt, rx0); end
    stop_cond();
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic b;
    tx_mem[tx_cnt[5:0]] = 8'h00;
    start_cond();
    write_byte({Dev, 1'b1}, a);
    for (int i = 0; i < 3; i++) recv_bit(b);
    #Q;
    checks++; if (SDA !== 1'b0) begin errors++; $display("FAIL mid_read_driving got=%b exp=0", SDA); end
    reset_n = 1'b0;
    #1;
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL mid_reset_sda got=%b exp=1", SDA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rx_data got=%h exp=00", rx_data); end
    checks++; if ({rx_valid, tx_req} !== 2'b00) begin errors++; $display("FAIL mid_reset_pulses got=%b exp=00", {rx_valid, tx_req}); end
    #(3 * ClkP);
    reset_n = 1'b1;
    SCL     = 1'b1;
    #(4 * Q);
    test_write(8'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_write(8'hA5);
    for (int i = 0; i < 3; i++) test_write(8'($urandom));
    test_wrong_addr(7'h15);
    test_wrong_addr(7'h00);
    for (int i = 0; i < 2; i++) begin
      logic [6:0] ad;
      do ad = 7'($urandom); while (ad == Dev);
      test_wrong_addr(ad);
    end
    test_write(8'($urandom));
    test_read(8'h3C, 8'hC3);
    test_read(8'($urandom), 8'($urandom));
    test_rx_not_ready(8'h11, 8'h22);
    test_repeated_start(8'($urandom));
    test_reset_mid_read();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rx_tx_overlap got=%0d exp=0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
